cve2_mac_seq: RTL and testbench

Iterative, multi-cycle multiply-accumulate unit in the cve2 EX stage. It computes (op_a * op_b) + acc, taking only the low 32 bits.
It feeds the EX result path through a valid/ready handshake. This lets the core drop the single-cycle 32x32 combinational MAC array in area-constrained configurations.
A shift-add datapath retires BITS_PER_CYCLE multiplier bits per clock.

---
 rtl/cve2_mac_seq.sv | 140 ++++++++++++++
 tb/tb_cve2_mac_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_mac_seq.sv
// ============================================================================
// Module   : cve2_mac_seq
// Brief    : Iterative shift-add multiply-accumulate, (a*b + acc) mod 2^32,
//            retiring BITS_PER_CYCLE multiplier bits per clock behind a
//            valid/ready handshake.
// Options  : CVE2_MAC_EARLY_OUT_EN - finish as soon as no multiplier bits remain
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cve2_pkg;
  typedef enum logic [6:0] {
    ALU_ADD = 7'd0,
    ALU_SUB = 7'd1,
    ALU_XOR = 7'd2,
    ALU_OR  = 7'd3,
    ALU_AND = 7'd4,
    ALU_MAC = 7'd5
  } alu_op_e;
endpackage

module cve2_mac_seq #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  cve2_pkg::alu_op_e alu_operator_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [31:0]       op_a_i,
  input  logic [31:0]       op_b_i,
  input  logic [31:0]       acc_i,
  input  logic              kill_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       result_o,
  output logic              busy_o
);

  localparam int unsigned c_N_STEPS  = 32 / BITS_PER_CYCLE;
  localparam logic [5:0]  c_CNT_LAST = 6'(c_N_STEPS - 1);

  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4 &&
      BITS_PER_CYCLE != 8 && BITS_PER_CYCLE != 16 && BITS_PER_CYCLE != 32)
  begin : g_bpc_check
    $error("cve2_mac_seq: BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_sum;
  logic [5:0]  r_cnt;
  logic [31:0] w_sum_step;
  logic [31:0] w_b_next;
  logic        w_accept;

  assign w_accept = valid_i && (r_state == S_IDLE) && !kill_i &&
                    (alu_operator_i == cve2_pkg::ALU_MAC);
  assign w_b_next = r_b >> BITS_PER_CYCLE;

  // One CALC step: add each shifted partial product selected by a multiplier bit.
  always_comb begin
    w_sum_step = r_sum;
    for (int k = 0; k < int'(BITS_PER_CYCLE); k++) begin
      if (r_b[k]) begin
        w_sum_step = w_sum_step + (r_a << k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (kill_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_state_nxt = S_CALC;
          end
        end
        S_CALC: begin
          if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = S_DONE;
          end
`ifdef CVE2_MAC_EARLY_OUT_EN
          else if (w_b_next == 32'd0) begin
            w_state_nxt = S_DONE;
          end
`endif
        end
        S_DONE: begin
          if (ready_i) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_sum   <= 32'd0;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a   <= op_a_i;
        r_b   <= op_b_i;
        r_sum <= acc_i;
        r_cnt <= 6'd0;
      end else if (r_state == S_CALC) begin
        r_a   <= r_a << BITS_PER_CYCLE;
        r_b   <= w_b_next;
        r_sum <= w_sum_step;
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

  assign ready_o  = (r_state == S_IDLE);
  assign valid_o  = (r_state == S_DONE);
  assign busy_o   = (r_state != S_IDLE);
  assign result_o = valid_o ? r_sum : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_cve2_mac_seq.sv
// Scoreboarded bench for cve2_mac_seq: one 1-bit/cycle and one 4-bit/cycle
// instance share stimulus; per-instance monitors check result and latency.
`default_nettype none

module tb_cve2_mac_seq;
  import cve2_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  alu_op_e     alu_op = ALU_ADD;
  logic        valid_i = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, acc = '0;
  logic        kill_i = 1'b0;
  logic        ready_i = 1'b1;

  logic        rdy1, vld1, busy1, rdy4, vld4, busy4;
  logic [31:0] res1, res4;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q1[$];
  exp_t q4[$];
  bit   seen1 = 0, post1 = 0, seen4 = 0, post4 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cve2_mac_seq #(.BITS_PER_CYCLE(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .alu_operator_i(alu_op), .valid_i(valid_i),
    .ready_o(rdy1), .op_a_i(op_a), .op_b_i(op_b), .acc_i(acc), .kill_i(kill_i),
    .valid_o(vld1), .ready_i(ready_i), .result_o(res1), .busy_o(busy1)
  );

  cve2_mac_seq #(.BITS_PER_CYCLE(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_i), .alu_operator_i(alu_op), .valid_i(valid_i),
    .ready_o(rdy4), .op_a_i(op_a), .op_b_i(op_b), .acc_i(acc), .kill_i(kill_i),
    .valid_o(vld4), .ready_i(ready_i), .result_o(res4), .busy_o(busy4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Monitor for the 1-bit/cycle instance.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (post1) begin
        chk("d1_ready_after_hs", {31'd0, rdy1}, 32'd1);
        chk("d1_valid_after_hs", {31'd0, vld1}, 32'd0);
        post1 = 0;
      end
      if (vld1) begin
        if (q1.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL d1_unexpected_valid: got result %h, required no valid", res1);
        end else begin
          if (!seen1) begin
            chk("d1_latency", 32'(cyc - q1[0].cyc), 32'd32);
            seen1 = 1;
          end
          chk("d1_result", res1, q1[0].res);
          if (ready_i) begin
            void'(q1.pop_front());
            seen1 = 0;
            post1 = 1;
          end
        end
      end else begin
        chk("d1_result_zero", res1, 32'd0);
      end
    end
  end

  // Monitor for the 4-bit/cycle instance.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (post4) begin
        chk("d4_ready_after_hs", {31'd0, rdy4}, 32'd1);
        chk("d4_valid_after_hs", {31'd0, vld4}, 32'd0);
        post4 = 0;
      end
      if (vld4) begin
        if (q4.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL d4_unexpected_valid: got result %h, required no valid", res4);
        end else begin
          if (!seen4) begin
            chk("d4_latency", 32'(cyc - q4[0].cyc), 32'd8);
            seen4 = 1;
          end
          chk("d4_result", res4, q4[0].res);
          if (ready_i) begin
            void'(q4.pop_front());
            seen4 = 0;
            post4 = 1;
          end
        end
      end else begin
        chk("d4_result_zero", res4, 32'd0);
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [31:0] exp, input bit push);
    int t = 0;
    while (!(rdy1 && rdy4) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) fail_now("issue_wait_ready");
    alu_op  = ALU_MAC;
    op_a    = a;
    op_b    = b;
    acc     = c;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    if (push) begin
      q1.push_back('{res: exp, cyc: cyc});
      q4.push_back('{res: exp, cyc: cyc});
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((q1.size() != 0 || q4.size() != 0) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) fail_now("drain");
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ready1"},  {31'd0, rdy1},  32'd1);
    chk({nm, "_valid1"},  {31'd0, vld1},  32'd0);
    chk({nm, "_result1"}, res1,           32'd0);
    chk({nm, "_busy1"},   {31'd0, busy1}, 32'd0);
    chk({nm, "_ready4"},  {31'd0, rdy4},  32'd1);
    chk({nm, "_valid4"},  {31'd0, vld4},  32'd0);
    chk({nm, "_result4"}, res4,           32'd0);
    chk({nm, "_busy4"},   {31'd0, busy4}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst_i = 1'b0;

    issue(32'd3, 32'd5, 32'd7, 32'd22, 1);                           drain();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0000_0001, 1);    drain();
    issue(32'h0001_0000, 32'h0001_0000, 32'd5, 32'h0000_0005, 1);    drain();
    issue(32'h8000_0000, 32'd3, 32'd1, 32'h8000_0001, 1);            drain();
    issue(32'd1000, 32'd1000, 32'hFFFF_FFFF, 32'd999999, 1);         drain();
    issue(32'd5, 32'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);            drain();

    // Backpressure: hold the result for 10 cycles in DONE.
    ready_i = 1'b0;
    issue(32'hFFFF_FFFF, 32'd7, 32'd10, 32'd3, 1);
    begin
      int t = 0;
      while (!(vld1 && vld4) && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 100) fail_now("backpressure_wait_valid");
    end
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid1", {31'd0, vld1}, 32'd1);
      chk("bp_valid4", {31'd0, vld4}, 32'd1);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    drain();

    // Kill in the 3rd CALC cycle: no result, then a normal request.
    issue(32'd11, 32'd13, 32'd17, 32'd0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    @(negedge clk);
    chk_idle("kill");
    repeat (40) @(posedge clk);
    #1;
    issue(32'd2, 32'd2, 32'd1, 32'd5, 1);                            drain();

    // Kill in IDLE blocks acceptance.
    alu_op = ALU_MAC; op_a = 32'd4; op_b = 32'd4; acc = 32'd4;
    valid_i = 1'b1; kill_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; kill_i = 1'b0;
    @(negedge clk);
    chk("kill_idle_busy1", {31'd0, busy1}, 32'd0);
    chk("kill_idle_busy4", {31'd0, busy4}, 32'd0);
    @(posedge clk); #1;

    // Reset mid-CALC, then a non-MAC request must be ignored.
    issue(32'd7, 32'd8, 32'd9, 32'd0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk_idle("rst_mid");
    @(posedge clk); #1;
    alu_op = ALU_ADD; op_a = 32'd1; op_b = 32'd1; acc = 32'd1;
    valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("add_ignored_busy1", {31'd0, busy1}, 32'd0);
      chk("add_ignored_busy4", {31'd0, busy4}, 32'd0);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;

    issue(32'd6, 32'd7, 32'd8, 32'd50, 1);                           drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
